// File: rtl/nested_isqrt_pkg.sv
// Shared sizing helpers for the nested integer square-root pipeline.
package nested_isqrt_pkg;

    function automatic int latency(input int n_terms, input int isqrt_stages);
        return n_terms * isqrt_stages;
    endfunction

    function automatic int inflight_w(input int n_terms, input int isqrt_stages);
        return $clog2(latency(n_terms, isqrt_stages) + 1);
    endfunction

endpackage

// File: rtl/nested_isqrt_pipe_if.sv
// Operand/result bundle of the nested isqrt pipeline; master drives operands, slave returns results.
interface nested_isqrt_pipe_if
    import nested_isqrt_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N_TERMS      = 3,
    parameter int ISQRT_STAGES = 4,
    parameter int TAG_W        = 8
);
    logic                                              arg_vld;
    logic [N_TERMS*WIDTH-1:0]                          args;
    logic [TAG_W-1:0]                                  arg_tag;
    logic                                              res_vld;
    logic [WIDTH/2-1:0]                                res;
    logic [TAG_W-1:0]                                  res_tag;
    logic                                              res_ovf;
    logic [inflight_w(N_TERMS, ISQRT_STAGES)-1:0]      in_flight;

    modport master (
        output arg_vld, args, arg_tag,
        input  res_vld, res, res_tag, res_ovf, in_flight
    );

    modport slave (
        input  arg_vld, args, arg_tag,
        output res_vld, res, res_tag, res_ovf, in_flight
    );
endinterface

// File: rtl/nested_isqrt_pipe_isqrt.sv
// Pipelined bit-by-bit integer square root; the WIDTH/2 digit iterations are spread evenly over the stages.
module isqrt #(
    parameter int WIDTH         = 32,
    parameter int n_pipe_stages = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_vld,
    output logic [WIDTH/2-1:0]   out_data
);
    localparam int ITER = WIDTH / 2;

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
        localparam int LO = (s * ITER) / n_pipe_stages;
        localparam int HI = ((s + 1) * ITER) / n_pipe_stages;

        logic [WIDTH-1:0] op_in_s, root_in_s, op_s, root_s, one_s;
        logic             vld_in_s;
        logic [WIDTH-1:0] op_r, root_r;
        logic             vld_r;

        if (s == 0) begin : g_src
            assign op_in_s   = in_data;
            assign root_in_s = {WIDTH{1'b0}};
            assign vld_in_s  = in_vld;
        end else begin : g_src
            assign op_in_s   = g_stage[s-1].op_r;
            assign root_in_s = g_stage[s-1].root_r;
            assign vld_in_s  = g_stage[s-1].vld_r;
        end

        // Digit iterations LO..HI-1 of the remainder/root recurrence.
        always_comb begin
            op_s   = op_in_s;
            root_s = root_in_s;
            one_s  = {WIDTH{1'b0}};
            for (int i = LO; i < HI; i++) begin
                one_s = WIDTH'(1) << (WIDTH - 2 - 2 * i);
                if (op_s >= root_s + one_s) begin
                    op_s   = op_s - (root_s + one_s);
                    root_s = (root_s >> 1) + one_s;
                end else begin
                    root_s = root_s >> 1;
                end
            end
        end

        // Stage valid, cleared asynchronously.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_in_s;
            end
        end

        // Stage data, loaded only for valid work and never reset.
        always_ff @(posedge clk) begin
            if (vld_in_s) begin
                op_r   <= op_s;
                root_r <= root_s;
            end
        end
    end

    assign out_vld  = g_stage[n_pipe_stages-1].vld_r;
    assign out_data = g_stage[n_pipe_stages-1].root_r[WIDTH/2-1:0];
endmodule

// File: rtl/nested_isqrt_pipe.sv
// Nested square root res = isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))) with saturating inner sums,
// one operand set per cycle, fixed latency N_TERMS*ISQRT_STAGES.
module nested_isqrt_pipe
    import nested_isqrt_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N_TERMS      = 3,
    parameter int ISQRT_STAGES = 4,
    parameter int TAG_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nested_isqrt_pipe_if.slave   bus
);
    localparam int AW   = N_TERMS * WIDTH;
    localparam int HW   = WIDTH / 2;
    localparam int FW   = inflight_w(N_TERMS, ISQRT_STAGES);
    localparam int LAST = N_TERMS - 1;

    for (genvar j = 0; j < N_TERMS; j++) begin : g_lvl
        logic [AW-1:0]    in_args_s, out_args_s;
        logic [TAG_W-1:0] in_tag_s, out_tag_s;
        logic             in_ovf_s, out_ovf_s, in_vld_s, root_vld_s;
        logic [WIDTH-1:0] in_op_s;
        logic [HW-1:0]    root_s;

        if (j == 0) begin : g_src
            assign in_args_s = bus.args;
            assign in_tag_s  = bus.arg_tag;
            assign in_vld_s  = bus.arg_vld;
            assign in_ovf_s  = 1'b0;
            assign in_op_s   = bus.args[(N_TERMS-1)*WIDTH +: WIDTH];
        end else begin : g_src
            // One extra bit captures the carry that forces saturation.
            logic [WIDTH:0] sum_s;
            assign sum_s = {1'b0, g_lvl[j-1].out_args_s[(N_TERMS-1-j)*WIDTH +: WIDTH]}
                         + {{(HW+1){1'b0}}, g_lvl[j-1].root_s};
            assign in_op_s   = sum_s[WIDTH] ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
            assign in_ovf_s  = g_lvl[j-1].out_ovf_s | sum_s[WIDTH];
            assign in_args_s = g_lvl[j-1].out_args_s;
            assign in_tag_s  = g_lvl[j-1].out_tag_s;
            assign in_vld_s  = g_lvl[j-1].root_vld_s;
        end

        isqrt #(
            .WIDTH         (WIDTH),
            .n_pipe_stages (ISQRT_STAGES)
        ) u_isqrt (
            .clk      (clk),
            .rst      (~rst_n),
            .in_vld   (in_vld_s),
            .in_data  (in_op_s),
            .out_vld  (root_vld_s),
            .out_data (root_s)
        );

        for (genvar s = 0; s < ISQRT_STAGES; s++) begin : g_dl
            logic [AW-1:0]    d_args_s, args_r;
            logic [TAG_W-1:0] d_tag_s, tag_r;
            logic             d_ovf_s, ovf_r, ld_s, vld_r;

            if (s == 0) begin : g_src
                assign d_args_s = in_args_s;
                assign d_tag_s  = in_tag_s;
                assign d_ovf_s  = in_ovf_s;
                assign ld_s     = in_vld_s;
            end else begin : g_src
                assign d_args_s = g_dl[s-1].args_r;
                assign d_tag_s  = g_dl[s-1].tag_r;
                assign d_ovf_s  = g_dl[s-1].ovf_r;
                assign ld_s     = g_dl[s-1].vld_r;
            end

            // Delay-line valid tracking the isqrt stage it shadows.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= 1'b0;
                end else begin
                    vld_r <= ld_s;
                end
            end

            // Sideband payload, loaded only when this stage receives a set.
            always_ff @(posedge clk) begin
                if (ld_s) begin
                    args_r <= d_args_s;
                    tag_r  <= d_tag_s;
                    ovf_r  <= d_ovf_s;
                end
            end
        end

        assign out_args_s = g_dl[ISQRT_STAGES-1].args_r;
        assign out_tag_s  = g_dl[ISQRT_STAGES-1].tag_r;
        assign out_ovf_s  = g_dl[ISQRT_STAGES-1].ovf_r;
    end

    logic          res_vld_s;
    logic [FW-1:0] in_flight_r;

    assign res_vld_s = g_lvl[LAST].root_vld_s;

    // Occupancy: +1 on accept, -1 on emit, unchanged when both or neither.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_r <= FW'(0);
        end else begin
            case ({bus.arg_vld, res_vld_s})
                2'b10:   in_flight_r <= in_flight_r + FW'(1);
                2'b01:   in_flight_r <= in_flight_r - FW'(1);
                default: in_flight_r <= in_flight_r;
            endcase
        end
    end

    assign bus.res_vld   = res_vld_s;
    assign bus.res       = res_vld_s ? g_lvl[LAST].root_s : {HW{1'bx}};
    assign bus.res_tag   = g_lvl[LAST].out_tag_s;
    assign bus.res_ovf   = (N_TERMS == 1) ? 1'b0 : g_lvl[LAST].out_ovf_s;
    assign bus.in_flight = in_flight_r;
endmodule

// File: doc/nested_isqrt_pipe.md
NESTED_ISQRT_PIPE -- requirements
Module: nested_isqrt_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; even, >= 4.
REQ-002 Parameter N_TERMS, default 3, number of nested square-root levels and operands; >= 1.
REQ-003 Parameter ISQRT_STAGES, default 4, pipeline depth of each isqrt instance.
REQ-004 Parameter TAG_W, default 8, width of the sideband tag carried alongside each operand set.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 arg_vld  input  1  operand set valid; may be high every cycle.
REQ-008 args  input  N_TERMS*WIDTH  packed operands; x[k] = args[k*WIDTH +: WIDTH], k = 0..N_TERMS-1.
REQ-009 arg_tag  input  TAG_W  sideband tag, sampled with arg_vld.
REQ-010 res_vld  output  1  result valid.
REQ-011 res  output  WIDTH/2  result.
REQ-012 res_tag  output  TAG_W  tag of the operand set producing res.
REQ-013 res_ovf  output  1  at least one inner addition saturated for this result.
REQ-014 in_flight  output  $clog2(N_TERMS*ISQRT_STAGES+1)  count of accepted sets not yet emitted.

Function
REQ-015 Level 0 SHALL compute r0 = isqrt(x[N_TERMS-1]); level j>0 SHALL compute rj = isqrt(sat(x[N_TERMS-1-j] + r(j-1))); res = r(N_TERMS-1).
REQ-016 Default parameters SHALL yield res = isqrt(x0 + isqrt(x1 + isqrt(x2))).
REQ-017 sat() SHALL add at WIDTH+1 bits and clamp to 2^WIDTH-1 on carry-out; a carry at any level SHALL set that set's res_ovf.
REQ-018 Latency SHALL be exactly N_TERMS*ISQRT_STAGES cycles from arg_vld sample to res_vld, fixed and independent of data.
REQ-019 Throughput SHALL be one operand set per cycle with no backpressure; back-to-back and gapped input SHALL both be supported.
REQ-020 res_vld SHALL follow arg_vld delayed by the latency, cycle for cycle; results SHALL emerge in input order.
REQ-021 Operand, tag and ovf delay registers SHALL load only when the valid for their stage is high (power gating); they SHALL hold otherwise.
REQ-022 When res_vld is low, res, res_tag and res_ovf are don't-care; simulation SHALL drive X on res.
REQ-023 in_flight SHALL increment when arg_vld is high, decrement when res_vld is high, and be unchanged when both or neither are high.
REQ-024 in_flight SHALL never exceed N_TERMS*ISQRT_STAGES; exceeding it is an assertion failure.
REQ-025 N_TERMS = 1 SHALL degenerate to a single isqrt of x[0], with res_ovf constant 0.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear res_vld, every internal stage valid and in_flight to 0, including mid-stream.
REQ-027 Operand and result data registers SHALL NOT be reset.
REQ-028 Sets in flight at reset SHALL be discarded; none SHALL emerge after release.
REQ-029 The first arg_vld after release SHALL be accepted normally.

Structure
REQ-030 Exactly N_TERMS isqrt instances SHALL be created by a generate loop, with n_pipe_stages = ISQRT_STAGES and rst driven by ~rst_n.
REQ-031 The per-level operand/tag/ovf delay lines SHALL be the only other storage.
REQ-032 Shared package nested_isqrt_pkg SHALL hold the latency function (N_TERMS*ISQRT_STAGES) and the in_flight width function.
REQ-033 The single sub-module is isqrt; no other sub-module.

Verification
REQ-034 Defaults, one set x0=9, x1=12, x2=16 -> res=3, res_ovf=0, res_vld exactly 12 cycles later.
REQ-035 Defaults, all operands 0xFFFFFFFF -> res=0xFFFF, res_ovf=1.
REQ-036 20 back-to-back random sets with tags 0..19 -> 20 consecutive res_vld cycles, tags in order, results matching the reference model.
REQ-037 Random arg_vld at 50% density over 1000 sets -> res_vld pattern equals arg_vld delayed 12 cycles; in_flight matches the model every cycle.
REQ-038 rst_n pulsed low with 6 sets in flight -> res_vld=0 and in_flight=0 immediately; no result emerges afterwards; the next set returns correctly after 12 cycles.
REQ-039 N_TERMS=1, WIDTH=16, ISQRT_STAGES=2, x0=0x0100 -> res=0x10 after 2 cycles.
